// File: rtl/smc_rd_arb.sv
// smc_rd_arb: shares one System Memory Controller read port between N
// requesters.
//
// Address channel: requesters are arbitrated round-robin. The winning
// request is loaded into a registered output stage (smc_addr/smc_len/
// smc_aid/smc_avalid). The winner sees req_aready in the same cycle it
// is loaded. Each requester may have at most MAX_OUTST bursts
// outstanding. A burst counts from its acceptance here until its last
// beat is returned.
//
// Data channel: returned beats are steered combinationally to the
// requester selected by smc_id. Beats carrying an id with no requester
// behind it are accepted and dropped, and they set the sticky err flag.
// A last beat for a requester with no outstanding burst also sets err.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_addr/req_len/req_avalid   per-requester address requests (slice i = requester i)
//   req_aready                    per-requester address accept
//   req_data/req_last             returned data, broadcast to all requesters
//   req_valid/req_ready           per-requester data handshake
//   smc_aid/smc_addr/smc_len      registered address request to the controller
//   smc_avalid/smc_aready         controller address handshake
//   smc_id/smc_data/smc_last      returned beat from the controller
//   smc_strb                      byte strobes (ignored)
//   smc_valid/smc_ready           controller data handshake
//   err                           sticky unroutable-id / unexpected-last flag
module smc_rd_arb #(
  parameter int  N         = 4,
  parameter int  ADDR_W    = 32,
  parameter int  LEN_W     = 16,
  parameter int  DATA_W    = 64,
  parameter int  MAX_OUTST = 4,
  localparam int ID_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*ADDR_W-1:0] req_addr,
  input  logic [N*LEN_W-1:0]  req_len,
  input  logic [N-1:0]        req_avalid,
  output logic [N-1:0]        req_aready,
  output logic [DATA_W-1:0]   req_data,
  output logic                req_last,
  output logic [N-1:0]        req_valid,
  input  logic [N-1:0]        req_ready,
  output logic [ID_W-1:0]     smc_aid,
  output logic [ADDR_W-1:0]   smc_addr,
  output logic [LEN_W-1:0]    smc_len,
  output logic                smc_avalid,
  input  logic                smc_aready,
  input  logic [ID_W-1:0]     smc_id,
  input  logic [DATA_W-1:0]   smc_data,
  input  logic [DATA_W/8-1:0] smc_strb,
  input  logic                smc_valid,
  output logic                smc_ready,
  input  logic                smc_last,
  output logic                err
);

  localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0]  cnt [N];
  logic [ID_W-1:0]   rr_ptr;
  logic [N-1:0]      elig;
  logic              hi_any, lo_any;
  logic [ID_W-1:0]   hi_idx, lo_idx;
  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic              load;
  logic [ADDR_W-1:0] grant_addr;
  logic [LEN_W-1:0]  grant_len;
  logic              id_hit;
  logic [N-1:0]      dec;
  logic              unused_strb;

  assign unused_strb = ^smc_strb;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N; i++) begin
      elig[i] = req_avalid[i] && (cnt[i] < CNT_MAX);
    end
  end

  // The circular search starting at rr_ptr+1 is split into two linear
  // scans. The lowest eligible index above rr_ptr wins. Otherwise the
  // lowest eligible index at or below rr_ptr wins (the wrapped part).
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (elig[i]) begin
        if (i > 32'(rr_ptr)) begin
          if (!hi_any) begin
            hi_any = 1'b1;
            hi_idx = ID_W'(i);
          end
        end else if (!lo_any) begin
          lo_any = 1'b1;
          lo_idx = ID_W'(i);
        end
      end
    end
  end

  assign grant_any = hi_any || lo_any;
  assign grant_idx = hi_any ? hi_idx : lo_idx;
  assign load      = grant_any && (!smc_avalid || smc_aready);

  always_comb begin
    grant_addr = '0;
    grant_len  = '0;
    req_aready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_addr    = req_addr[i*ADDR_W +: ADDR_W];
        grant_len     = req_len[i*LEN_W +: LEN_W];
        req_aready[i] = load;
      end
    end
  end

  // An id that matches no requester leaves smc_ready at 1, so the beat
  // is consumed and dropped.
  always_comb begin
    req_valid = '0;
    dec       = '0;
    smc_ready = 1'b1;
    id_hit    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (smc_id == ID_W'(i)) begin
        id_hit       = 1'b1;
        req_valid[i] = smc_valid;
        smc_ready    = req_ready[i];
        dec[i]       = smc_valid && smc_last && req_ready[i];
      end
    end
  end

  assign req_data = smc_data;
  assign req_last = smc_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      smc_avalid <= 1'b0;
      smc_addr   <= '0;
      smc_len    <= '0;
      smc_aid    <= '0;
      rr_ptr     <= ID_W'(N - 1);
      err        <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      if (load) begin
        smc_avalid <= 1'b1;
        smc_addr   <= grant_addr;
        smc_len    <= grant_len;
        smc_aid    <= grant_idx;
        rr_ptr     <= grant_idx;
      end else if (smc_aready) begin
        smc_avalid <= 1'b0;
      end

      if (smc_valid && !id_hit) begin
        err <= 1'b1;
      end

      for (int unsigned i = 0; i < N; i++) begin
        if (req_aready[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (dec[i] && !req_aready[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
        if (dec[i] && (cnt[i] == '0)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_smc_rd_arb.sv
// Testbench for smc_rd_arb.
// The main instance uses N=4 and MAX_OUTST=2.
// A second instance uses N=3 and exercises the unroutable-id error path.
module tb_smc_rd_arb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int DW = 64;
  localparam int MO = 2;

  localparam logic [AW-1:0] ADDR_TAB [4] = '{32'h0000_A000, 32'h0000_B000, 32'h0000_1000, 32'h0000_D000};
  localparam logic [LW-1:0] LEN_TAB  [4] = '{16'd1, 16'd2, 16'd8, 16'd4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]  req_avalid, req_aready, req_valid, req_ready;
  logic [DW-1:0] req_data, smc_data;
  logic          req_last, smc_avalid, smc_aready, smc_valid, smc_ready, smc_last, err;
  logic [1:0]    smc_aid, smc_id;
  logic [AW-1:0] smc_addr;
  logic [LW-1:0] smc_len;
  logic [DW/8-1:0] smc_strb;

  smc_rd_arb #(.N(N), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTST(MO)) u_dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_len(req_len), .req_avalid(req_avalid), .req_aready(req_aready),
    .req_data(req_data), .req_last(req_last), .req_valid(req_valid), .req_ready(req_ready),
    .smc_aid(smc_aid), .smc_addr(smc_addr), .smc_len(smc_len), .smc_avalid(smc_avalid),
    .smc_aready(smc_aready), .smc_id(smc_id), .smc_data(smc_data), .smc_strb(smc_strb),
    .smc_valid(smc_valid), .smc_ready(smc_ready), .smc_last(smc_last), .err(err)
  );

  // N=3 instance
  logic          rst3;
  logic [3*AW-1:0] addr3;
  logic [3*LW-1:0] len3;
  logic [2:0]    avalid3, aready3, valid3, ready3;
  logic [DW-1:0] data3_o, sdata3;
  logic          last3_o, savalid3, saready3, svalid3, sready3, slast3, err3;
  logic [1:0]    aid3, id3;
  logic [AW-1:0] saddr3;
  logic [LW-1:0] slen3;
  logic [DW/8-1:0] strb3;

  smc_rd_arb #(.N(3), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTST(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .req_addr(addr3), .req_len(len3), .req_avalid(avalid3), .req_aready(aready3),
    .req_data(data3_o), .req_last(last3_o), .req_valid(valid3), .req_ready(ready3),
    .smc_aid(aid3), .smc_addr(saddr3), .smc_len(slen3), .smc_avalid(savalid3),
    .smc_aready(saready3), .smc_id(id3), .smc_data(sdata3), .smc_strb(strb3),
    .smc_valid(svalid3), .smc_ready(sready3), .smc_last(slast3), .err(err3)
  );

  typedef struct {
    logic [3:0]    avalid;
    logic          sar;
    logic          v;
    logic [1:0]    id;
    logic          last;
    logic [3:0]    rdy;
    logic [3:0]    e_ar;
    logic          e_av;
    logic [1:0]    e_aid;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [3:0]    e_val;
    logic          e_sr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // e_aid < 0 means the output register still holds its reset contents
  function automatic vec_t mk(logic [3:0] av, logic sar, logic v, logic [1:0] id, logic last,
                              logic [3:0] rdy, logic [3:0] e_ar, logic e_av, int e_aid,
                              logic [3:0] e_val, logic e_sr);
    vec_t r;
    r.avalid = av; r.sar = sar; r.v = v; r.id = id; r.last = last; r.rdy = rdy;
    r.e_ar = e_ar; r.e_av = e_av; r.e_val = e_val; r.e_sr = e_sr;
    if (e_aid < 0) begin
      r.e_aid = 2'd0; r.e_addr = '0; r.e_len = '0;
    end else begin
      r.e_aid = 2'(e_aid); r.e_addr = ADDR_TAB[e_aid]; r.e_len = LEN_TAB[e_aid];
    end
    return r;
  endfunction

  initial begin
    vec_t tab[$];
    int g, j, m_ptr, m_aid;
    int m_cnt [N];
    bit m_av, m_err, load_ok, inc, dec;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_len;
    logic [3:0] e_ar, e_val;
    logic e_sr;

    // round robin, all requesters asking, controller always ready
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0001, 1'b0, -1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0010, 1'b1,  0, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0100, 1'b1,  1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b1000, 1'b1,  2, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0001, 1'b1,  3, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0010, 1'b1,  0, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0100, 1'b1,  1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b1000, 1'b1,  2, 4'b0000, 1'b1));
    // every counter at MAX_OUTST: no further grants
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  3, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b0,  3, 4'b0000, 1'b1));
    // 4-beat burst to id 3, req_ready[3] = 1,0,1,1,0,1
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1111, 4'b0000, 1'b0,  3, 4'b1000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0111, 4'b0000, 1'b0,  3, 4'b1000, 1'b0));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1111, 4'b0000, 1'b0,  3, 4'b1000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4'b1111, 4'b0000, 1'b0,  3, 4'b1000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b0111, 4'b0000, 1'b0,  3, 4'b1000, 1'b0));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1111, 4'b0000, 1'b0,  3, 4'b1000, 1'b1));
    // cnt[3] dropped by exactly one: one grant, then blocked
    tab.push_back(mk(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b1000, 1'b0,  3, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  3, 4'b0000, 1'b1));
    tab.push_back(mk(4'b1000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b0,  3, 4'b0000, 1'b1));
    // drain req 1, then three requests from req 1
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0,  3, 4'b0010, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0,  3, 4'b0010, 1'b1));
    tab.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0010, 1'b0,  3, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0010, 1'b1,  1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b1111, 4'b0000, 1'b0,  1, 4'b0010, 1'b1));
    tab.push_back(mk(4'b0010, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0010, 1'b0,  1, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  1, 4'b0000, 1'b1));
    // drain req 2, then a grant stalled 5 cycles by smc_aready=0
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b1111, 4'b0000, 1'b0,  1, 4'b0100, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd2, 1'b1, 4'b1111, 4'b0000, 1'b0,  1, 4'b0100, 1'b1));
    tab.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0100, 1'b0,  1, 4'b0000, 1'b1));
    for (int k = 0; k < 5; k++)
      tab.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1, 2, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  2, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b0,  2, 4'b0000, 1'b1));
    // req 0: cnt 2->1, then increment and decrement together leave it at 1
    tab.push_back(mk(4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1111, 4'b0000, 1'b0,  2, 4'b0001, 1'b1));
    tab.push_back(mk(4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1111, 4'b0001, 1'b0,  2, 4'b0001, 1'b1));
    tab.push_back(mk(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0001, 1'b1,  0, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b1,  0, 4'b0000, 1'b1));
    tab.push_back(mk(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000, 1'b0,  0, 4'b0000, 1'b1));

    rst = 1'b1; rst3 = 1'b1;
    req_avalid = '0; smc_aready = 1'b0; smc_valid = 1'b0; smc_id = '0; smc_last = 1'b0;
    req_ready = '0; smc_data = '0; smc_strb = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ADDR_TAB[i];
      req_len[i*LW +: LW]  = LEN_TAB[i];
    end
    addr3 = '0; len3 = '0; avalid3 = '0; ready3 = '0; saready3 = 1'b0; id3 = '0;
    sdata3 = '0; strb3 = '0; svalid3 = 1'b0; slast3 = 1'b0;
    tick(); tick();
    rst = 1'b0; rst3 = 1'b0;

    for (int r = 0; r < tab.size(); r++) begin
      req_avalid = tab[r].avalid; smc_aready = tab[r].sar; smc_valid = tab[r].v;
      smc_id = tab[r].id; smc_last = tab[r].last; req_ready = tab[r].rdy;
      #1;
      chk($sformatf("row%0d req_aready", r), req_aready, tab[r].e_ar);
      chk($sformatf("row%0d smc_avalid", r), smc_avalid, tab[r].e_av);
      chk($sformatf("row%0d smc_aid", r), smc_aid, tab[r].e_aid);
      chk($sformatf("row%0d smc_addr", r), smc_addr, tab[r].e_addr);
      chk($sformatf("row%0d smc_len", r), smc_len, tab[r].e_len);
      chk($sformatf("row%0d req_valid", r), req_valid, tab[r].e_val);
      chk($sformatf("row%0d smc_ready", r), smc_ready, tab[r].e_sr);
      tick();
    end
    chk("table err", err, 1'b0);

    // reset in the middle of traffic
    req_avalid = 4'b1111; smc_aready = 1'b1; smc_valid = 1'b0; req_ready = 4'b1111;
    #1;
    chk("pre-rst grant", req_aready, 4'b0100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req_avalid = 4'b0001;
    #1;
    chk("post-rst smc_avalid", smc_avalid, 1'b0);
    chk("post-rst smc_aid", smc_aid, 2'd0);
    chk("post-rst smc_addr", smc_addr, 32'd0);
    chk("post-rst first grant", req_aready, 4'b0001);
    tick();
    #1;
    chk("post-rst second grant", req_aready, 4'b0001);
    chk("post-rst smc_avalid set", smc_avalid, 1'b1);
    tick();
    #1;
    chk("post-rst cnt limit", req_aready, 4'b0000);
    tick();

    // randomized traffic against a reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = N - 1; m_aid = 0; m_av = 1'b0; m_err = 1'b0; m_addr = '0; m_len = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    for (int c = 0; c < 600; c++) begin
      req_avalid = 4'($urandom);
      smc_aready = ($urandom_range(0, 3) != 0);
      smc_valid  = 1'($urandom_range(0, 1));
      smc_id     = 2'($urandom_range(0, 3));
      smc_last   = ($urandom_range(0, 2) == 0);
      req_ready  = 4'($urandom);
      smc_data   = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW] = $urandom;
        req_len[i*LW +: LW]  = 16'($urandom);
      end
      #1;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req_avalid[j] && m_cnt[j] < MO) g = j;
      end
      load_ok = (g >= 0) && (!m_av || smc_aready);
      e_ar  = load_ok ? 4'(1 << g) : 4'b0000;
      e_sr  = req_ready[smc_id];
      e_val = smc_valid ? 4'(1 << smc_id) : 4'b0000;
      chk($sformatf("rnd%0d req_aready", c), req_aready, e_ar);
      chk($sformatf("rnd%0d smc_avalid", c), smc_avalid, m_av);
      chk($sformatf("rnd%0d smc_aid", c), smc_aid, 64'(m_aid));
      chk($sformatf("rnd%0d smc_addr", c), smc_addr, m_addr);
      chk($sformatf("rnd%0d smc_len", c), smc_len, m_len);
      chk($sformatf("rnd%0d err", c), err, m_err);
      chk($sformatf("rnd%0d req_valid", c), req_valid, e_val);
      chk($sformatf("rnd%0d smc_ready", c), smc_ready, e_sr);
      chk($sformatf("rnd%0d req_data", c), req_data, smc_data);
      chk($sformatf("rnd%0d req_last", c), req_last, smc_last);
      for (int i = 0; i < N; i++) begin
        inc = load_ok && (g == i);
        dec = smc_valid && e_sr && smc_last && (smc_id == 2'(i));
        if (dec && m_cnt[i] == 0) m_err = 1'b1;
        if (inc && !dec) m_cnt[i]++;
        else if (dec && !inc && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (load_ok) begin
        m_av = 1'b1; m_aid = g; m_ptr = g;
        m_addr = req_addr[g*AW +: AW];
        m_len  = req_len[g*LW +: LW];
      end else if (m_av && smc_aready) begin
        m_av = 1'b0;
      end
      tick();
    end

    // N=3: id 3 has no requester
    svalid3 = 1'b1; id3 = 2'd2; ready3 = 3'b011; slast3 = 1'b0;
    #1;
    chk("n3 id2 smc_ready", sready3, 1'b0);
    chk("n3 id2 req_valid", valid3, 3'b100);
    chk("n3 err before", err3, 1'b0);
    tick();
    id3 = 2'd3; ready3 = 3'b000;
    #1;
    chk("n3 id3 smc_ready", sready3, 1'b1);
    chk("n3 id3 req_valid", valid3, 3'b000);
    tick();
    svalid3 = 1'b0; id3 = 2'd0;
    #1;
    chk("n3 err set", err3, 1'b1);
    tick();
    tick();
    chk("n3 err held", err3, 1'b1);
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    #1;
    chk("n3 err cleared", err3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smc_rd_arb.md
Name: smc_rd_arb

Overview:
- Shares one System Memory Controller read port (smc_rd_if, master side) between N ANB read requesters (anb_rd_if, slave side toward each requester).
- Address channel: round-robin arbitration, registered output stage, requester index driven as aid.
- Data channel: demultiplexed back to the requester addressed by returned id.
- Per-requester outstanding-burst limiting; sticky error flag for unroutable ids.

Parameters:
- N, 4, number of requesters (1..16).
- ADDR_W, 32, address width.
- LEN_W, 16, burst length width.
- DATA_W, 64, data width; strobe width is DATA_W/8.
- MAX_OUTST, 4, max bursts in flight per requester (1..15).
- ID_W (local), clog2(N) when N>1, else 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_addr  in  N*ADDR_W  requester addresses; slice i belongs to requester i.
- req_len  in  N*LEN_W  requester burst lengths.
- req_avalid  in  N  address valid per requester.
- req_aready  out  N  address accept per requester.
- req_data  out  DATA_W  read data, broadcast to all requesters.
- req_last  out  1  last beat, broadcast.
- req_valid  out  N  data valid per requester.
- req_ready  in  N  data ready per requester.
- smc_aid  out  ID_W  granted requester index.
- smc_addr  out  ADDR_W  address to controller.
- smc_len  out  LEN_W  burst length to controller.
- smc_avalid  out  1  address valid to controller.
- smc_aready  in  1  controller accepts address.
- smc_id  in  ID_W  id of returned beat.
- smc_data  in  DATA_W  returned data.
- smc_strb  in  DATA_W/8  byte strobes; unused, ignored.
- smc_valid  in  1  returned beat valid.
- smc_ready  out  1  arbiter accepts beat.
- smc_last  in  1  last beat of burst.
- err  out  1  sticky: beat received with smc_id >= N.

Behaviour:
- Reset values: smc_avalid=0, smc_addr=0, smc_len=0, smc_aid=0, err=0, all outstanding counters=0, rr_ptr=N-1 (requester 0 has first priority).
- Eligibility: requester i is eligible when req_avalid[i]=1 and cnt[i] < MAX_OUTST.
- Output register load: load = eligible_any & (!smc_avalid | smc_aready).
- Grant (combinational): first eligible index searching rr_ptr+1, rr_ptr+2, … with wrap modulo N.
- On load:
  - smc_addr, smc_len and smc_aid capture the granted slice and index.
  - smc_avalid<=1; req_aready[g]=1 in the same cycle; all other req_aready are 0.
  - rr_ptr<=g.
- smc_avalid & smc_aready with no load: smc_avalid<=0.
- Stability: while smc_avalid=1 and smc_aready=0, smc_addr, smc_len and smc_aid hold.
- Throughput: back-to-back grants, one address per cycle while smc_aready=1.
- Latency: requester accept to smc_avalid is 1 cycle.
- cnt[i] increments on req_aready[i] (accept at arbiter input, not at the controller).
- cnt[i] decrements on smc_valid & smc_ready & smc_last with smc_id=i.
- Simultaneous increment and decrement on the same counter: value unchanged.
- Counter width clog2(MAX_OUTST+1); it never exceeds MAX_OUTST and never underflows.
- A last beat arriving for cnt=0 leaves cnt at 0 and sets err.
- Data demux (combinational, zero latency):
  - req_valid[i] = smc_valid & (smc_id==i).
  - smc_ready = req_ready[smc_id].
  - req_data and req_last are driven directly from smc_data and smc_last.
- Unroutable id (smc_id >= N, possible only when N is not a power of 2):
  - smc_ready=1, so the beat is dropped.
  - No req_valid is asserted.
  - err<=1 and stays set until rst.
- N=1: arbitration degenerates to pass-through with the register stage; smc_aid=0.
- rst mid-burst: all state returns to reset values. The controller must also be reset; in-flight beats after reset are not tracked.

Test Plan:
- N=4, requesters 0..3 all hold avalid, smc_aready=1 constant -> grants 0,1,2,3,0… on consecutive cycles; smc_aid follows; one req_aready per cycle.
- Req 2 only, addr=0x1000, len=8, smc_aready low 5 cycles -> smc_avalid=1 with addr=0x1000 held steady for 5 cycles; req_aready[2] high for 1 cycle only; no new grant until accepted.
- MAX_OUTST=2, req 1 issues 3 requests, no data returned -> 2 grants, then req_aready[1]=0; a last beat with id=1 -> third request granted the following cycle.
- Return a 4-beat burst id=3, req_ready[3] toggling 1,0,1,1,0,1 -> req_valid[3] follows smc_valid; smc_ready mirrors req_ready[3]; req_valid[0..2]=0; cnt[3] decrements once, on the last beat.
- N=3, inject beat smc_id=3 -> smc_ready=1, no req_valid, err=1 and held; rst -> err=0.
- Increment and last-beat decrement on req 0 in the same cycle with cnt=1 -> cnt stays 1; assert rst mid-traffic -> smc_avalid=0 next cycle, counters=0, requester 0 granted first afterwards.
